// File: rtl/axis_pkt_stats_mon.sv
// Passive AXI4-Stream statistics monitor: packet/beat/error/oversize counters plus FSM state word.
// Optional macro STATS_BYTE_COUNT_EN adds a saturating byte_num counter driven by popcount(s_tkeep).
module axis_pkt_stats_mon #(
    parameter int DATA_WIDTH = 64,
    parameter int KEEP_WIDTH = DATA_WIDTH / 8,
    parameter int MIN_WORDS  = 1,
    parameter int MAX_WORDS  = 190,
    parameter int LEN_WIDTH  = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESETN,
    input  logic [DATA_WIDTH-1:0] s_tdata,
    input  logic [KEEP_WIDTH-1:0] s_tkeep,
    input  logic                  s_tvalid,
    input  logic                  s_tready,
    input  logic                  s_tlast,
    input  logic                  clr_stats,
    output logic [31:0]           pkt_num,
    output logic [31:0]           word_num,
    output logic [31:0]           error_num,
    output logic [31:0]           extra_word,
`ifdef STATS_BYTE_COUNT_EN
    output logic [31:0]           byte_num,
`endif
    output logic [2:0]            state_output
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_PKT  = 2'd1,
        S_OVER = 2'd2
    } state_e;

    localparam logic [LEN_WIDTH-1:0]  LEN_ONE  = LEN_WIDTH'(1);
    localparam logic [LEN_WIDTH-1:0]  LEN_SAT  = '1;
    localparam logic [LEN_WIDTH-1:0]  MIN_LEN  = LEN_WIDTH'(MIN_WORDS);
    localparam logic [LEN_WIDTH-1:0]  MAX_LEN  = LEN_WIDTH'(MAX_WORDS);
    localparam logic [KEEP_WIDTH-1:0] KEEP_ONE = KEEP_WIDTH'(1);

    function automatic logic [31:0] sat_add(input logic [31:0] base, input logic [31:0] inc);
        logic [32:0] sum;
        sum = {1'b0, base} + {1'b0, inc};
        return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
    endfunction

    function automatic logic [31:0] popcount(input logic [KEEP_WIDTH-1:0] k);
        logic [31:0] cnt;
        cnt = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) begin
            cnt = cnt + {31'b0, k[i]};
        end
        return cnt;
    endfunction

    // Payload is not inspected; this only keeps the tap port visible to lint.
    logic unused_tdata;
    assign unused_tdata = ^s_tdata;

    state_e                 state_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic                   bad_q;
    logic [31:0]            pkt_num_q, word_num_q, error_num_q, extra_word_q;
    logic [31:0]            pkt_num_d, word_num_d, error_num_d, extra_word_d;
    logic                   sat_q, sat_d;
`ifdef STATS_BYTE_COUNT_EN
    logic [31:0]            byte_num_q, byte_num_d;
`endif

    logic                   beat, close;
    logic                   keep_contig, keep_err;
    logic [KEEP_WIDTH-1:0]  keep_inc;
    logic [LEN_WIDTH-1:0]   new_len;
    logic                   is_extra, pkt_bad;

    assign beat  = s_tvalid & s_tready;
    assign close = beat & s_tlast;

    // A legal last-beat keep is 0..01..1: nonzero and keep & (keep+1) == 0.
    assign keep_inc    = s_tkeep + KEEP_ONE;
    assign keep_contig = (s_tkeep != '0) && ((s_tkeep & keep_inc) == '0);
    assign keep_err    = s_tlast ? !keep_contig : (s_tkeep != '1);

    // The length saturates rather than wrapping so oversize stays visible.
    assign new_len  = (state_q == S_IDLE) ? LEN_ONE
                    : ((len_q == LEN_SAT) ? len_q : len_q + LEN_ONE);
    assign is_extra = beat && ((state_q == S_OVER) ||
                               ((state_q == S_PKT) && (new_len > MAX_LEN)));
    assign pkt_bad  = bad_q || keep_err || (state_q == S_OVER) ||
                      (new_len < MIN_LEN) || (new_len > MAX_LEN);

    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!ARESETN) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            bad_q   <= 1'b0;
        end else if (beat) begin
            if (s_tlast) begin
                state_q <= S_IDLE;
                len_q   <= '0;
                bad_q   <= 1'b0;
            end else begin
                len_q   <= new_len;
                bad_q   <= bad_q | keep_err;
                if (state_q == S_IDLE) begin
                    state_q <= S_PKT;
                end else if (is_extra) begin
                    state_q <= S_OVER;
                end
            end
        end
    end

    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        logic [31:0] pkt_base, word_base, err_base, extra_base;
        pkt_base   = clr_stats ? 32'd0 : pkt_num_q;
        word_base  = clr_stats ? 32'd0 : word_num_q;
        err_base   = clr_stats ? 32'd0 : error_num_q;
        extra_base = clr_stats ? 32'd0 : extra_word_q;

        pkt_num_d    = sat_add(pkt_base,   {31'b0, close});
        word_num_d   = sat_add(word_base,  {31'b0, beat});
        error_num_d  = sat_add(err_base,   {31'b0, close & pkt_bad});
        extra_word_d = sat_add(extra_base, {31'b0, is_extra});

        sat_d = (clr_stats ? 1'b0 : sat_q) |
                (pkt_num_d == '1) | (word_num_d == '1) |
                (error_num_d == '1) | (extra_word_d == '1);
`ifdef STATS_BYTE_COUNT_EN
        byte_num_d = sat_add(clr_stats ? 32'd0 : byte_num_q,
                             beat ? popcount(s_tkeep) : 32'd0);
        sat_d      = sat_d | (byte_num_d == '1);
`endif
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            pkt_num_q    <= '0;
            word_num_q   <= '0;
            error_num_q  <= '0;
            extra_word_q <= '0;
            sat_q        <= 1'b0;
`ifdef STATS_BYTE_COUNT_EN
            byte_num_q   <= '0;
`endif
        end else begin
            pkt_num_q    <= pkt_num_d;
            word_num_q   <= word_num_d;
            error_num_q  <= error_num_d;
            extra_word_q <= extra_word_d;
            sat_q        <= sat_d;
`ifdef STATS_BYTE_COUNT_EN
            byte_num_q   <= byte_num_d;
`endif
        end
    end

    assign pkt_num      = pkt_num_q;
    assign word_num     = word_num_q;
    assign error_num    = error_num_q;
    assign extra_word   = extra_word_q;
    assign state_output = {sat_q, state_q};
`ifdef STATS_BYTE_COUNT_EN
    assign byte_num     = byte_num_q;
`endif

endmodule

// File: tb/tb_axis_pkt_stats_mon.sv
// Scoreboard bench for axis_pkt_stats_mon: directed beats push hand-computed expectations,
// a cycle-tagged monitor pops and compares them one ns after the targeted clock edge.
module tb_axis_pkt_stats_mon;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [63:0] s_tdata = '0;
    logic [7:0]  s_tkeep = '0;
    logic        s_tvalid = 1'b0;
    logic        s_tready = 1'b0;
    logic        s_tlast = 1'b0;
    logic        clr_stats = 1'b0;
    logic [31:0] pkt_num, word_num, error_num, extra_word;
    logic [2:0]  state_output;
`ifdef STATS_BYTE_COUNT_EN
    logic [31:0] byte_num;
`endif

    axis_pkt_stats_mon dut (
        .ACLK        (ACLK),
        .ARESETN     (ARESETN),
        .s_tdata     (s_tdata),
        .s_tkeep     (s_tkeep),
        .s_tvalid    (s_tvalid),
        .s_tready    (s_tready),
        .s_tlast     (s_tlast),
        .clr_stats   (clr_stats),
        .pkt_num     (pkt_num),
        .word_num    (word_num),
        .error_num   (error_num),
        .extra_word  (extra_word),
`ifdef STATS_BYTE_COUNT_EN
        .byte_num    (byte_num),
`endif
        .state_output(state_output)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        int          tgt;
        string       tag;
        logic [31:0] pkt, word, err, extra, bytes;
        logic [2:0]  st;
    } exp_t;

    exp_t exp_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%08h required 0x%08h", name, act, req);
        end
    endtask

    // Expectation for the state right after the clock edge following the current drive.
    task automatic push_exp(input string tag, input logic [31:0] pkt, input logic [31:0] word,
                            input logic [31:0] err, input logic [31:0] extra,
                            input logic [2:0] st, input logic [31:0] bytes);
        exp_t e;
        e.tgt = cyc + 1; e.tag = tag; e.pkt = pkt; e.word = word;
        e.err = err; e.extra = extra; e.st = st; e.bytes = bytes;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic r, input logic [7:0] k,
                         input logic l, input logic c);
        @(negedge ACLK);
        s_tvalid  = v;
        s_tready  = r;
        s_tkeep   = k;
        s_tlast   = l;
        clr_stats = c;
        s_tdata   = {8{k}};
    endtask

    task automatic send(input logic [7:0] k, input logic l);
        drive(1'b1, 1'b1, k, l, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge ACLK);
            cyc++;
            #1;
            while (exp_q.size() > 0 && exp_q[0].tgt <= cyc) begin
                e = exp_q.pop_front();
                if (e.tgt < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s: stale expectation for cycle %0d seen at cycle %0d",
                             e.tag, e.tgt, cyc);
                end else begin
                    check({e.tag, ".pkt_num"},    pkt_num,    e.pkt);
                    check({e.tag, ".word_num"},   word_num,   e.word);
                    check({e.tag, ".error_num"},  error_num,  e.err);
                    check({e.tag, ".extra_word"}, extra_word, e.extra);
                    check({e.tag, ".state"},      {29'b0, state_output}, {29'b0, e.st});
`ifdef STATS_BYTE_COUNT_EN
                    check({e.tag, ".byte_num"},   byte_num,   e.bytes);
`endif
                end
            end
        end
    end

    initial begin : stimulus
        // Reset with a beat presented: nothing may count.
        drive(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 8'hFF, 1'b1, 1'b0);
        push_exp("reset", 0, 0, 0, 0, 3'd0, 0);
        idle();
        ARESETN = 1'b1;
        push_exp("reset_release", 0, 0, 0, 0, 3'd0, 0);

        // Three 4-beat packets, last beat keep 0x0F.
        for (int p = 0; p < 3; p++) begin
            send(8'hFF, 1'b0);
            if (p == 0) push_exp("pkt_first_beat", 0, 1, 0, 0, 3'd1, 8);
            send(8'hFF, 1'b0);
            send(8'hFF, 1'b0);
            send(8'h0F, 1'b1);
            push_exp("pkt_close", p + 1, 4 * (p + 1), 0, 0, 3'd0, 28 * (p + 1));
        end
        idle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        push_exp("clr_alone", 0, 0, 0, 0, 3'd0, 0);
        idle();

        // 193-beat packet: beats 191..193 are extra.
        for (int i = 1; i <= 193; i++) begin
            send(8'hFF, i == 193);
            if (i == 190) push_exp("len_at_max",   0, 190, 0, 0, 3'd1, 1520);
            if (i == 191) push_exp("len_over_max", 0, 191, 0, 1, 3'd2, 1528);
            if (i == 193) push_exp("over_close",   1, 193, 1, 3, 3'd0, 1544);
        end
        idle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        idle();

        // tkeep error cases.
        send(8'hFF, 1'b0);
        send(8'hF0, 1'b0);
        send(8'hFF, 1'b0);
        send(8'h01, 1'b1);
        push_exp("keep_mid_gap", 1, 4, 1, 0, 3'd0, 21);
        send(8'hFF, 1'b0);
        send(8'h05, 1'b1);
        push_exp("keep_last_noncontig", 2, 6, 2, 0, 3'd0, 31);
        send(8'h00, 1'b1);
        push_exp("keep_last_zero", 3, 7, 3, 0, 3'd0, 31);
        send(8'h01, 1'b1);
        push_exp("keep_ok_single", 4, 8, 3, 0, 3'd0, 32);
        idle();
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        idle();

        // Valid without ready for 10 cycles, then one accepted last beat.
        for (int i = 0; i < 10; i++) drive(1'b1, 1'b0, 8'hFF, 1'b1, 1'b0);
        push_exp("no_ready", 0, 0, 0, 0, 3'd0, 0);
        send(8'hFF, 1'b1);
        push_exp("ready_beat", 1, 1, 0, 0, 3'd0, 8);

        // Five more packets, then clear coinciding with a last beat.
        for (int i = 0; i < 5; i++) send(8'h0F, 1'b1);
        push_exp("five_pkts", 6, 6, 0, 0, 3'd0, 28);
        drive(1'b1, 1'b1, 8'hFF, 1'b1, 1'b1);
        push_exp("clr_with_beat", 1, 1, 0, 0, 3'd0, 8);
        idle();

        // Reset mid-packet; remaining beats form a new packet.
        send(8'hFF, 1'b0);
        push_exp("mid_pkt", 1, 2, 0, 0, 3'd1, 16);
        idle();
        ARESETN = 1'b0;
        push_exp("mid_pkt_reset", 0, 0, 0, 0, 3'd0, 0);
        idle();
        ARESETN = 1'b1;
        send(8'hFF, 1'b0);
        push_exp("after_rst_first", 0, 1, 0, 0, 3'd1, 8);
        send(8'h0F, 1'b1);
        push_exp("after_rst_close", 1, 2, 0, 0, 3'd0, 12);
        idle();

        // Saturation of word_num and the sticky sat flag.
        @(negedge ACLK);
        force dut.word_num_q = 32'hFFFF_FFFE;
        #1;
        release dut.word_num_q;
        send(8'hFF, 1'b1);
        push_exp("sat_hit", 2, 32'hFFFF_FFFF, 0, 0, 3'd4, 20);
        send(8'hFF, 1'b1);
        push_exp("sat_hold1", 3, 32'hFFFF_FFFF, 0, 0, 3'd4, 28);
        send(8'hFF, 1'b1);
        push_exp("sat_hold2", 4, 32'hFFFF_FFFF, 0, 0, 3'd4, 36);
        idle();
        push_exp("sat_sticky", 4, 32'hFFFF_FFFF, 0, 0, 3'd4, 36);
        drive(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        push_exp("sat_clr", 0, 0, 0, 0, 3'd0, 0);
        idle();

        // Two-beat packet, keep 0xFF then 0x07: 11 bytes.
        send(8'hFF, 1'b0);
        send(8'h07, 1'b1);
        push_exp("bytes_two_beat", 1, 2, 0, 0, 3'd0, 11);
        idle();

        repeat (3) @(negedge ACLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations never compared", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
